// File: rtl/cache_miss_ctrl.sv
// Miss-handling sequencer: victim choice, optional dirty writeback, line fetch, LFSR advance.
// Optional performance counters are compiled in when CACHE_MISS_PERF_EN is defined.
module cache_miss_ctrl #(
    parameter  int NUMWAYS = 4,
    parameter  int LINELEN = 256,
    parameter  int AHBW    = 64,
    localparam int BEATS   = LINELEN / AHBW,
    localparam int BCW     = $clog2(BEATS)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               FlushStage,
    input  logic               CacheMiss,
    input  logic [NUMWAYS-1:0] ValidWay,
    input  logic [NUMWAYS-1:0] DirtyWay,
    input  logic [NUMWAYS-1:0] LFSRVictimWay,
    input  logic               BusAck,
    output logic [NUMWAYS-1:0] VictimWay,
    output logic               LFSRWriteEn,
    output logic               BusReq,
    output logic               BusWrite,
    output logic [BCW-1:0]     BeatCount,
    output logic               LineWriteEn,
    output logic               CacheStall,
    output logic               MissDone
`ifdef CACHE_MISS_PERF_EN
    ,
    output logic [31:0]        MissCount,
    output logic [31:0]        WritebackCount
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_VICTIM,
        S_WRITEBACK,
        S_FETCH,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [NUMWAYS-1:0] r_victim_way;
    logic [NUMWAYS-1:0] w_victim_way_next;
    logic               r_used_lfsr;
    logic               w_used_lfsr_next;
    logic [BCW-1:0]     r_beat_count;
    logic [BCW-1:0]     w_beat_count_next;
    logic               w_last_beat;
    logic               w_all_valid;
    logic [NUMWAYS-1:0] w_first_invalid;
    logic [NUMWAYS:0]   w_invalid_seen;
    logic [NUMWAYS-1:0] w_new_victim;

    // Ripple priority chain: a way is chosen only if no lower way is invalid.
    assign w_invalid_seen[0] = 1'b0;
    generate
        for (genvar gi = 0; gi < NUMWAYS; gi++) begin : g_first_invalid
            assign w_first_invalid[gi]  = ~ValidWay[gi] & ~w_invalid_seen[gi];
            assign w_invalid_seen[gi+1] = w_invalid_seen[gi] | ~ValidWay[gi];
        end
    endgenerate

    assign w_all_valid  = &ValidWay;
    assign w_new_victim = w_all_valid ? LFSRVictimWay : w_first_invalid;
    assign w_last_beat  = (r_beat_count == BCW'(BEATS - 1));

    assign VictimWay = r_victim_way;
    assign BeatCount = r_beat_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_victim_way <= '0;
            r_used_lfsr  <= 1'b0;
            r_beat_count <= '0;
        end else begin
            r_state      <= w_state_next;
            r_victim_way <= w_victim_way_next;
            r_used_lfsr  <= w_used_lfsr_next;
            r_beat_count <= w_beat_count_next;
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_victim_way_next = r_victim_way;
        w_used_lfsr_next  = r_used_lfsr;
        w_beat_count_next = r_beat_count;
        LFSRWriteEn       = 1'b0;
        BusReq            = 1'b0;
        BusWrite          = 1'b0;
        LineWriteEn       = 1'b0;
        CacheStall        = 1'b0;
        MissDone          = 1'b0;
        case (r_state)
            S_IDLE: begin
                CacheStall = CacheMiss;
                if (CacheMiss && !FlushStage) begin
                    w_state_next      = S_VICTIM;
                    w_victim_way_next = w_new_victim;
                    w_used_lfsr_next  = w_all_valid;
                end
            end
            S_VICTIM: begin
                CacheStall        = 1'b1;
                w_beat_count_next = '0;
                if (FlushStage)
                    w_state_next = S_IDLE;
                else if (|(r_victim_way & DirtyWay & ValidWay))
                    w_state_next = S_WRITEBACK;
                else
                    w_state_next = S_FETCH;
            end
            S_WRITEBACK: begin
                CacheStall = 1'b1;
                BusReq     = 1'b1;
                BusWrite   = 1'b1;
                if (BusAck) begin
                    w_beat_count_next = r_beat_count + BCW'(1);
                    if (w_last_beat)
                        w_state_next = S_FETCH;
                end
            end
            S_FETCH: begin
                CacheStall  = 1'b1;
                BusReq      = 1'b1;
                LineWriteEn = BusAck;
                if (BusAck) begin
                    w_beat_count_next = r_beat_count + BCW'(1);
                    if (w_last_beat)
                        w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                MissDone     = 1'b1;
                LFSRWriteEn  = r_used_lfsr;
                w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

`ifdef CACHE_MISS_PERF_EN
    logic [31:0] r_miss_count;
    logic [31:0] r_wb_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_miss_count <= '0;
            r_wb_count   <= '0;
        end else begin
            if (MissDone)
                r_miss_count <= r_miss_count + 32'd1;
            if (r_state == S_VICTIM && w_state_next == S_WRITEBACK)
                r_wb_count <= r_wb_count + 32'd1;
        end
    end

    assign MissCount      = r_miss_count;
    assign WritebackCount = r_wb_count;
`endif

endmodule

// File: tb/tb_cache_miss_ctrl.sv
// Randomized bench for cache_miss_ctrl; expectations come from a transaction-level model
// (victim rule plus ack-stream arithmetic), never from DUT state.
module tb_cache_miss_ctrl;
    localparam int NW    = 4;
    localparam int BEATS = 4;
    localparam int MAXC  = 400;

    logic          clk = 1'b0;
    logic          reset;
    logic          FlushStage;
    logic          CacheMiss;
    logic [NW-1:0] ValidWay;
    logic [NW-1:0] DirtyWay;
    logic [NW-1:0] LFSRVictimWay;
    logic          BusAck;
    logic [NW-1:0] VictimWay;
    logic          LFSRWriteEn;
    logic          BusReq;
    logic          BusWrite;
    logic [1:0]    BeatCount;
    logic          LineWriteEn;
    logic          CacheStall;
    logic          MissDone;
`ifdef CACHE_MISS_PERF_EN
    logic [31:0]   MissCount;
    logic [31:0]   WritebackCount;
`endif

    cache_miss_ctrl #(.NUMWAYS(NW), .LINELEN(256), .AHBW(64)) u_dut (
        .clk           (clk),
        .reset         (reset),
        .FlushStage    (FlushStage),
        .CacheMiss     (CacheMiss),
        .ValidWay      (ValidWay),
        .DirtyWay      (DirtyWay),
        .LFSRVictimWay (LFSRVictimWay),
        .BusAck        (BusAck),
        .VictimWay     (VictimWay),
        .LFSRWriteEn   (LFSRWriteEn),
        .BusReq        (BusReq),
        .BusWrite      (BusWrite),
        .BeatCount     (BeatCount),
        .LineWriteEn   (LineWriteEn),
        .CacheStall    (CacheStall),
        .MissDone      (MissDone)
`ifdef CACHE_MISS_PERF_EN
        ,
        .MissCount     (MissCount),
        .WritebackCount(WritebackCount)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int n_miss   = 0;

    // Model state: last registered victim and expected counter values.
    logic [NW-1:0] m_victim = '0;
    int            m_miss_cnt = 0;
    int            m_wb_cnt = 0;
    bit            ack_s[MAXC];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [NW-1:0] pick_victim(input logic [NW-1:0] valid, input logic [NW-1:0] lfsr);
        logic [NW-1:0] one;
        one = 1;
        if (&valid) return lfsr;
        for (int i = 0; i < NW; i++)
            if (!valid[i]) return one << i;
        return '0;
    endfunction

    // Runs one miss starting in an IDLE cycle (just after an edge); returns in an IDLE cycle.
    // flush_mode: 0 none, 1 blocked in IDLE for one cycle, 2 cancelled in VICTIM.
    task automatic run_miss(input logic [NW-1:0] valid, input logic [NW-1:0] dirty,
                            input logic [NW-1:0] lfsr, input int ack_mode,
                            input int flush_mode, input bit rst_mid);
        logic [NW-1:0] exp_v;
        bit            is_dirty;
        bit            wr;
        int            k, cnt, c_last, n;
        exp_v    = pick_victim(valid, lfsr);
        is_dirty = |(exp_v & dirty & valid);
        k        = is_dirty ? 2 * BEATS : BEATS;
        for (int c = 0; c < MAXC; c++) begin
            case (ack_mode)
                0:       ack_s[c] = 1'b1;
                1:       ack_s[c] = (c % 2) == 1;
                default: ack_s[c] = $urandom_range(0, 3) != 0;
            endcase
        end
        cnt    = 0;
        c_last = -1;
        for (int c = 2; c < MAXC - 1; c++) begin
            if (ack_s[c]) cnt++;
            if (cnt == k) begin
                c_last = c;
                break;
            end
        end
        chk("ack_budget", (c_last > 0), 1);
        if (c_last <= 0) return;

        ValidWay      = valid;
        DirtyWay      = dirty;
        LFSRVictimWay = lfsr;
        CacheMiss     = 1'b1;
        if (flush_mode == 1) begin
            FlushStage = 1'b1;
            BusAck     = 1'b1;
            @(posedge clk); #1;
            #1;
            chk("flush_idle_req", BusReq, 0);
            chk("flush_idle_victim", VictimWay, m_victim);
            chk("flush_idle_stall", CacheStall, 1);
        end
        FlushStage = 1'b0;
        BusAck     = ack_s[0];
        #1;
        chk("idle_stall", CacheStall, 1);
        chk("idle_req", BusReq, 0);
        chk("idle_done", MissDone, 0);

        @(posedge clk); #1;
        BusAck     = ack_s[1];
        FlushStage = (flush_mode == 2);
        #1;
        m_victim = exp_v;
        chk("victim", VictimWay, exp_v);
        chk("victim_req", BusReq, 0);
        chk("victim_stall", CacheStall, 1);
        chk("victim_done", MissDone, 0);

        if (flush_mode == 2) begin
            @(posedge clk); #1;
            #1;
            chk("flush_req", BusReq, 0);
            chk("flush_victim_hold", VictimWay, m_victim);
            chk("flush_lfsr", LFSRWriteEn, 0);
            chk("flush_done", MissDone, 0);
            CacheMiss  = 1'b0;
            FlushStage = 1'b0;
            #1;
            chk("flush_stall", CacheStall, 0);
            n_miss++;
            $display("miss %0d valid=%b dirty=%b lfsr=%b victim=%b cancelled by flush", n_miss, valid, dirty, lfsr, exp_v);
            return;
        end
        if (is_dirty) m_wb_cnt++;

        n = 0;
        for (int c = 2; c <= c_last + 1; c++) begin
            @(posedge clk); #1;
            BusAck     = ack_s[c];
            FlushStage = 1'($urandom_range(0, 1));
            #1;
            if (c <= c_last) begin
                wr = is_dirty && (n < BEATS);
                if (rst_mid && !wr && (n % BEATS) == 2) begin
                    reset = 1'b1;
                    #1;
                    chk("rst_req", BusReq, 0);
                    chk("rst_beat", BeatCount, 0);
                    chk("rst_victim", VictimWay, 0);
                    chk("rst_done", MissDone, 0);
                    chk("rst_lfsr", LFSRWriteEn, 0);
                    chk("rst_stall", CacheStall, 1);
                    m_victim   = '0;
                    m_miss_cnt = 0;
                    m_wb_cnt   = 0;
                    CacheMiss  = 1'b0;
                    FlushStage = 1'b0;
                    BusAck     = 1'b0;
                    @(negedge clk);
                    reset = 1'b0;
                    @(posedge clk); #1;
                    chk("post_rst_req", BusReq, 0);
                    chk("post_rst_done", MissDone, 0);
                    chk("post_rst_lfsr", LFSRWriteEn, 0);
                    n_miss++;
                    $display("miss %0d valid=%b dirty=%b lfsr=%b victim=%b aborted by reset in fetch beat 2", n_miss, valid, dirty, lfsr, exp_v);
                    return;
                end
                chk("bus_req", BusReq, 1);
                chk("bus_write", BusWrite, wr);
                chk("beat", BeatCount, n % BEATS);
                chk("line_we", LineWriteEn, ack_s[c] && !wr);
                chk("bus_stall", CacheStall, 1);
                chk("bus_done", MissDone, 0);
                chk("bus_lfsr", LFSRWriteEn, 0);
                if (ack_s[c]) n++;
            end else begin
                chk("done", MissDone, 1);
                chk("done_lfsr", LFSRWriteEn, &valid);
                chk("done_stall", CacheStall, 0);
                chk("done_req", BusReq, 0);
                chk("done_line_we", LineWriteEn, 0);
`ifdef CACHE_MISS_PERF_EN
                chk("miss_count", MissCount, m_miss_cnt);
                chk("wb_count", WritebackCount, m_wb_cnt);
`endif
                m_miss_cnt++;
            end
        end
        n_miss++;
        $display("miss %0d valid=%b dirty=%b lfsr=%b victim=%b writeback=%0d done_cycle=%0d", n_miss, valid, dirty, lfsr, exp_v, is_dirty, c_last + 1);
        @(posedge clk); #1;
        chk("after_done_req", BusReq, 0);
        chk("after_done_lfsr", LFSRWriteEn, 0);
    endtask

    task automatic idle_gap(input int cycles);
        CacheMiss  = 1'b0;
        FlushStage = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            #1;
            chk("gap_stall", CacheStall, 0);
            chk("gap_req", BusReq, 0);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        logic [NW-1:0] one;
        logic [NW-1:0] v, d, l;
        int            fm;
        one           = 1;
        reset         = 1'b1;
        FlushStage    = 1'b0;
        CacheMiss     = 1'b0;
        ValidWay      = '0;
        DirtyWay      = '0;
        LFSRVictimWay = '0;
        BusAck        = 1'b1;
        #12;
        chk("rst_victim_way", VictimWay, 0);
        chk("rst_beatcount", BeatCount, 0);
        chk("rst_busreq", BusReq, 0);
        chk("rst_buswrite", BusWrite, 0);
        chk("rst_linewe", LineWriteEn, 0);
        chk("rst_missdone", MissDone, 0);
        chk("rst_lfsrwe", LFSRWriteEn, 0);
        chk("rst_stall_lo", CacheStall, 0);
`ifdef CACHE_MISS_PERF_EN
        chk("rst_miss_count", MissCount, 0);
        chk("rst_wb_count", WritebackCount, 0);
`endif
        CacheMiss = 1'b1;
        #1;
        chk("rst_stall_follow", CacheStall, 1);
        CacheMiss = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;

        run_miss(4'b0011, 4'b0000, 4'b0001, 0, 0, 0);
        run_miss(4'b1111, 4'b0010, 4'b0010, 0, 0, 0);
        run_miss(4'b1111, 4'b1111, 4'b0100, 1, 0, 0);
        run_miss(4'b0111, 4'b1111, 4'b0001, 0, 2, 0);
        idle_gap(1);
        run_miss(4'b1101, 4'b0000, 4'b0001, 0, 0, 1);
        run_miss(4'b1011, 4'b0100, 4'b1000, 0, 0, 0);
        run_miss(4'b1111, 4'b0000, 4'b1000, 0, 1, 0);

        for (int t = 0; t < 40; t++) begin
            v  = ($urandom_range(0, 1) == 1) ? 4'hF : NW'($urandom);
            d  = NW'($urandom);
            l  = one << $urandom_range(0, NW - 1);
            fm = $urandom_range(0, 9);
            run_miss(v, d, l, $urandom_range(0, 2), (fm == 0) ? 1 : (fm == 1) ? 2 : 0,
                     $urandom_range(0, 19) == 0);
            idle_gap($urandom_range(0, 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
